gf2_kmul_pipe: RTL and testbench

Parametrised, pipelined carry-less (GF(2)[x]) Karatsuba multiplier with valid/ready handshakes and full backpressure. It takes two W-bit polynomial operands and returns their 2W-1-bit carry-less product, or optionally the product reduced modulo a fixed degree-W polynomial. It sits between an operand source and a consumer in the GF arithmetic datapath and sustains one multiply per cycle.

---
 rtl/gf2_pkg.sv | 35 +++
 rtl/gf2_kmul_comb.sv | 50 +++++
 rtl/gf2_kmul_pipe.sv | 103 ++++++++++
 tb/tb_gf2_kmul_pipe.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gf2_pkg.sv
// Shared helpers for the GF(2)[x] multiplier datapath.
// Setting GF_REDUCE_EN adds the modular-reduction stage to the pipeline.
package gf2_pkg;

    localparam int unsigned MAX_W = 64;

    typedef logic [2*MAX_W-2:0] wide_t;
    typedef logic [MAX_W-1:0]   poly_t;

`ifdef GF_REDUCE_EN
    localparam int unsigned NUM_STAGES = 3;
`else
    localparam int unsigned NUM_STAGES = 2;
`endif

    function automatic int unsigned clmul_width(input int unsigned w);
        return 2*w - 1;
    endfunction

    // Folds bits 2w-2 down to w back into the low w bits using x^w = poly.
    function automatic wide_t gf_fold(input wide_t c, input int unsigned w, input poly_t poly);
        wide_t r;
        int unsigned i;
        r = c;
        for (int unsigned k = 0; k <= 2*MAX_W-2; k++) begin
            i = 2*MAX_W - 2 - k;
            if (i >= w && i <= 2*w - 2 && r[i]) begin
                r    = r ^ (wide_t'(poly) << (i - w));
                r[i] = 1'b0;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/gf2_kmul_comb.sv
// Combinational Karatsuba carry-less multiplier for H-bit operands.
// Recurses on itself down to a 2-bit schoolbook base case.
module gf2_kmul_comb
    import gf2_pkg::*;
#(
    parameter int unsigned H = 4
) (
    input  logic [H-1:0]                a,
    input  logic [H-1:0]                b,
    output logic [clmul_width(H)-1:0]   p
);

    if (H == 2) begin : g_base
        assign p[0] = a[0] & b[0];
        assign p[1] = (a[0] & b[1]) ^ (a[1] & b[0]);
        assign p[2] = a[1] & b[1];
    end else begin : g_rec
        localparam int unsigned Q = H / 2;

        logic [2*Q-2:0] p_hi;
        logic [2*Q-2:0] p_lo;
        logic [2*Q-2:0] p_mid;

        gf2_kmul_comb #(.H(Q)) u_hi (
            .a (a[H-1:Q]),
            .b (b[H-1:Q]),
            .p (p_hi)
        );

        gf2_kmul_comb #(.H(Q)) u_lo (
            .a (a[Q-1:0]),
            .b (b[Q-1:0]),
            .p (p_lo)
        );

        gf2_kmul_comb #(.H(Q)) u_mid (
            .a (a[H-1:Q] ^ a[Q-1:0]),
            .b (b[H-1:Q] ^ b[Q-1:0]),
            .p (p_mid)
        );

        always_comb begin
            p            = '0;
            p[2*H-2:H]   = p_hi;
            p[H+Q-2:Q]   = p[H+Q-2:Q] ^ (p_hi ^ p_lo ^ p_mid);
            p[2*Q-2:0]   = p[2*Q-2:0] ^ p_lo;
        end
    end

endmodule

// File: rtl/gf2_kmul_pipe.sv
// Pipelined carry-less Karatsuba multiplier with valid/ready backpressure.
// Defining GF_REDUCE_EN adds a third stage reducing modulo x^W + POLY.
module gf2_kmul_pipe
    import gf2_pkg::*;
#(
    parameter int unsigned   W    = 8,
    parameter logic [W-1:0]  POLY = 8'h1B
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [W-1:0]                in_a,
    input  logic [W-1:0]                in_b,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [clmul_width(W)-1:0]   out_c
);

    localparam int unsigned H  = W / 2;
    localparam int unsigned CW = clmul_width(W);
    localparam int unsigned PW = clmul_width(H);

    logic [PW-1:0] p1_next, p0_next, pm_next;
    logic [PW-1:0] p1, p0, pm;
    logic [CW-1:0] c_next, s2_c;
    logic          ready_en, s1_valid, s2_valid;
    logic          s1_adv, s2_adv, accept;

    gf2_kmul_comb #(.H(H)) u_p1 (.a(in_a[W-1:H]), .b(in_b[W-1:H]), .p(p1_next));
    gf2_kmul_comb #(.H(H)) u_p0 (.a(in_a[H-1:0]), .b(in_b[H-1:0]), .p(p0_next));
    gf2_kmul_comb #(.H(H)) u_pm (
        .a (in_a[W-1:H] ^ in_a[H-1:0]),
        .b (in_b[W-1:H] ^ in_b[H-1:0]),
        .p (pm_next)
    );

    always_comb begin
        c_next            = '0;
        c_next[CW-1:W]    = p1;
        c_next[W+H-2:H]   = c_next[W+H-2:H] ^ (p1 ^ p0 ^ pm);
        c_next[PW-1:0]    = c_next[PW-1:0] ^ p0;
    end

`ifdef GF_REDUCE_EN
    logic          s3_valid;
    logic [CW-1:0] s3_c;
    logic          s3_adv;

    assign s3_adv    = !s3_valid || out_ready;
    assign s2_adv    = !s2_valid || s3_adv;
    assign out_valid = s3_valid;
    assign out_c     = s3_c;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s3_valid <= 1'b0;
            s3_c     <= '0;
        end else if (s3_adv) begin
            s3_valid <= s2_valid;
            if (s2_valid)
                s3_c <= {{(W-1){1'b0}}, W'(gf_fold(wide_t'(s2_c), W, poly_t'(POLY)))};
        end
    end
`else
    assign s2_adv    = !s2_valid || out_ready;
    assign out_valid = s2_valid;
    assign out_c     = s2_c;
`endif

    // ready_en keeps in_ready low through reset and the first cycle after it
    assign s1_adv   = !s1_valid || s2_adv;
    assign in_ready = ready_en && s1_adv;
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ready_en <= 1'b0;
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            p1       <= '0;
            p0       <= '0;
            pm       <= '0;
            s2_c     <= '0;
        end else begin
            ready_en <= 1'b1;
            if (s1_adv) begin
                s1_valid <= accept;
                if (accept) begin
                    p1 <= p1_next;
                    p0 <= p0_next;
                    pm <= pm_next;
                end
            end
            if (s2_adv) begin
                s2_valid <= s1_valid;
                if (s1_valid)
                    s2_c <= c_next;
            end
        end
    end

endmodule

// File: tb/tb_gf2_kmul_pipe.sv
// Scoreboard bench for gf2_kmul_pipe; honours GF_REDUCE_EN like the RTL.
`timescale 1ns/1ps
module tb_gf2_kmul_pipe;

    localparam int unsigned W  = 8;
    localparam int unsigned CW = 2*W - 1;
`ifdef GF_REDUCE_EN
    localparam int unsigned LAT = 3;
    localparam bit          RED = 1'b1;
`else
    localparam int unsigned LAT = 2;
    localparam bit          RED = 1'b0;
`endif

    typedef struct {
        logic [63:0] exp;
        int unsigned acc;
        bit          lat;
    } entry_t;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          in_valid, in_ready, out_valid, out_ready;
    logic [W-1:0]  in_a, in_b;
    logic [CW-1:0] out_c;

    logic          in_valid4, in_ready4, out_valid4, out_ready4;
    logic [3:0]    in_a4, in_b4;
    logic [6:0]    out_c4;

    entry_t        exp_q[$];
    logic [63:0]   q4[$];
    int unsigned   n_pass = 0;
    int unsigned   n_total = 0;
    int unsigned   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    gf2_kmul_pipe #(.W(8), .POLY(8'h1B)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .out_valid(out_valid), .out_ready(out_ready),
        .out_c(out_c)
    );

    gf2_kmul_pipe #(.W(4), .POLY(4'h3)) dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4),
        .in_a(in_a4), .in_b(in_b4), .out_valid(out_valid4), .out_ready(out_ready4),
        .out_c(out_c4)
    );

    function automatic logic [63:0] sw_clmul(input logic [31:0] a, input logic [31:0] b,
                                             input int unsigned w);
        logic [63:0] c = '0;
        for (int unsigned i = 0; i < w; i++)
            for (int unsigned j = 0; j < w; j++)
                if (a[i] && b[j]) c[i+j] = c[i+j] ^ 1'b1;
        return c;
    endfunction

    function automatic logic [63:0] sw_expect(input logic [63:0] c, input int unsigned w,
                                              input logic [31:0] poly);
        logic [63:0] r = c;
        if (RED) begin
            for (int k = 2*int'(w) - 2; k >= int'(w); k--) begin
                if (r[k]) begin
                    r    = r ^ (64'(poly) << (k - int'(w)));
                    r[k] = 1'b0;
                end
            end
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Monitors: pop the scoreboard on every output transfer.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_out: got 0x%0h, expected no output", out_c);
            end else begin
                entry_t e;
                e = exp_q.pop_front();
                check("out_c", 64'(out_c), e.exp);
                if (e.lat) check("latency", 64'(cyc - e.acc), 64'(LAT));
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && out_valid4 && out_ready4) begin
            if (q4.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_out_w4: got 0x%0h, expected no output", out_c4);
            end else begin
                check("out_c_w4", 64'(out_c4), q4.pop_front());
            end
        end
    end

    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [63:0] exp,
                        input bit lat, input bit chk_rdy);
        int unsigned waited = 0;
        entry_t      e;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        @(negedge clk);
        if (chk_rdy) check("in_ready_stream", 64'(in_ready), 64'd1);
        while (!in_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            n_total++;
            $display("FAIL accept_timeout: in_ready=0 after %0d cycles, expected 1", waited);
        end else begin
            e.exp = exp;
            e.acc = cyc;
            e.lat = lat;
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic drain();
        int unsigned n = 0;
        while ((exp_q.size() != 0 || q4.size() != 0) && n < 100) begin
            @(posedge clk);
            #2 n++;
        end
        if (exp_q.size() != 0 || q4.size() != 0) begin
            n_total++;
            $display("FAIL drain_timeout: %0d results outstanding, expected 0",
                     exp_q.size() + q4.size());
            exp_q.delete();
            q4.delete();
        end
        @(posedge clk);
        #1;
    endtask

    logic [7:0]  da[7] = '{8'h57, 8'hFF, 8'h00, 8'h01, 8'h80, 8'hF0, 8'hAA};
    logic [7:0]  db[7] = '{8'h83, 8'hFF, 8'hC3, 8'hA5, 8'h80, 8'h0F, 8'hAA};
    logic [15:0] dc[7] = '{16'h2B79, 16'h5555, 16'h0000, 16'h00A5, 16'h4000, 16'h0550, 16'h4444};
    logic [7:0]  sa[5] = '{8'h12, 8'h56, 8'h9A, 8'hDE, 8'h0F};
    logic [7:0]  sb[5] = '{8'h34, 8'h78, 8'hBC, 8'hF0, 8'hE1};

    initial begin
        int unsigned   idx;
        int unsigned   seen;
        int unsigned   guard;
        logic [CW-1:0] held;
        bit            first_seen;
        logic [7:0]    ra, rb;

        in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b1;
        in_valid4 = 1'b0; in_a4 = '0; in_b4 = '0; out_ready4 = 1'b1;

        #1 rst = 1'b1;
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_c", 64'(out_c), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("ready_first_cycle", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1 check("ready_after_rst", 64'(in_ready), 64'd1);

        // Directed vectors with hand-computed full products
        if (RED) check("reduce_57x83", sw_expect(64'h2B79, 8, 32'h1B), 64'h00C1);
        for (int i = 0; i < 7; i++)
            send(da[i], db[i], sw_expect(64'(dc[i]), 8, 32'h1B), 1'b1, 1'b0);
        drain();

        // Back-to-back stream
        for (int i = 0; i < 16; i++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            send(ra, rb, sw_expect(sw_clmul(32'(ra), 32'(rb), 8), 8, 32'h1B), 1'b1, 1'b1);
        end
        drain();

        // Backpressure: fill with out_ready low, then release
        out_ready  = 1'b0;
        idx        = 0;
        first_seen = 1'b0;
        held       = '0;
        for (int c = 0; c < 5; c++) begin
            in_valid = 1'b1; in_a = sa[idx]; in_b = sb[idx];
            @(negedge clk);
            if (out_valid && !first_seen) begin
                first_seen = 1'b1;
                held       = out_c;
            end
            if (in_ready) begin
                exp_q.push_back('{sw_expect(sw_clmul(32'(sa[idx]), 32'(sb[idx]), 8), 8, 32'h1B),
                                  cyc, 1'b0});
                idx++;
            end
            @(posedge clk);
            #1;
        end
        check("stall_accepts", 64'(idx), 64'(LAT));
        @(negedge clk);
        check("stall_in_ready", 64'(in_ready), 64'd0);
        check("stall_out_valid", 64'(out_valid), 64'd1);
        check("stall_hold", 64'(out_c), 64'(held));
        check("stall_head", 64'(out_c), sw_expect(sw_clmul(32'h12, 32'h34, 8), 8, 32'h1B));
        @(posedge clk);
        #1 out_ready = 1'b1;
        guard = 0;
        while (idx < 5 && guard < 50) begin
            in_valid = 1'b1; in_a = sa[idx]; in_b = sb[idx];
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back('{sw_expect(sw_clmul(32'(sa[idx]), 32'(sb[idx]), 8), 8, 32'h1B),
                                  cyc, 1'b0});
                idx++;
            end
            @(posedge clk);
            #1 guard++;
        end
        in_valid = 1'b0;
        check("stall_all_accepted", 64'(idx), 64'd5);
        drain();

        // Reset with two results in flight
        out_ready = 1'b0;
        send(8'h57, 8'h83, 64'h0, 1'b0, 1'b0);
        send(8'h11, 8'h22, 64'h0, 1'b0, 1'b0);
        rst = 1'b1;
        #1;
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_out_c", 64'(out_c), 64'd0);
        check("midrst_in_ready", 64'(in_ready), 64'd0);
        exp_q.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        out_ready = 1'b1;
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("post_rst_quiet", 64'(seen), 64'd0);
        @(posedge clk);
        #1 send(8'hA5, 8'h3C, sw_expect(sw_clmul(32'hA5, 32'h3C, 8), 8, 32'h1B), 1'b1, 1'b1);
        drain();

        // W=4 instance
        for (int i = 0; i < 2; i++) begin
            in_valid4 = 1'b1;
            in_a4     = (i == 0) ? 4'hF : 4'h3;
            in_b4     = (i == 0) ? 4'hF : 4'h5;
            @(negedge clk);
            check("w4_in_ready", 64'(in_ready4), 64'd1);
            if (in_ready4) q4.push_back(sw_expect((i == 0) ? 64'h55 : 64'h0F, 4, 32'h3));
            @(posedge clk);
            #1 in_valid4 = 1'b0;
        end
        drain();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at 200000ns, expected finish");
        $fatal(1, "watchdog");
    end

endmodule
